sounder_rx_avg: RTL and testbench
=================================

Name: sounder_rx_avg

Overview:
- Coherent frame averager for the sounder RX chain; sits directly upstream of the RX output stream and owns one dual-port block RAM, instantiated from the shared bram_mem primitive, as its accumulator store.
- Accepts a stream of complex sc16 samples organised as repeated frames of frame_len samples.
- Sums 2^log2_avg consecutive frames element-wise by read-modify-write in the BRAM, then streams out one averaged frame of frame_len samples.

Parameters:
- AWIDTH, 10, BRAM address width; maximum frame length is 2^AWIDTH.
- MAX_LOG2_AVG, 8, maximum averaging exponent; accumulator width ACC_W = 16 + MAX_LOG2_AVG per I/Q rail.

Ports:
- clk  in  1  single clock; all logic is synchronous to its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse that latches configuration and begins a run; ignored unless state is IDLE.
- frame_len  in  AWIDTH+1  samples per frame; sampled on start; values 0 and 1 are treated as 2; values above 2^AWIDTH are clamped to 2^AWIDTH.
- log2_avg  in  4  averaging exponent; sampled on start; clamped to MAX_LOG2_AVG.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when the last output sample is accepted downstream.
- frame_err  out  1  sticky; cleared on start.
- s_tdata  in  32  input sample, I in [31:16], Q in [15:0], signed.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  input last; checked, not used for framing.
- s_tready  out  1  input ready.
- m_tdata  out  32  averaged sample, same I/Q packing as the input.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  high on the last sample of the averaged frame.
- m_tready  in  1  output ready.

Behaviour:
- Reset values: busy=0, done=0, frame_err=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0; state IDLE; all counters 0. Reset may assert at any time; it aborts the run immediately and the BRAM contents become don't-care.
- States and transitions:
  - IDLE -> ACCUM on start when log2_avg > 0.
  - IDLE -> LAST on start when log2_avg = 0.
  - ACCUM -> LAST after frame 2^log2_avg − 2 completes.
  - LAST -> FLUSH after the final input sample is accepted.
  - FLUSH -> IDLE once the pipeline is empty and the last output is accepted; done pulses in that same cycle.
- Counters:
  - idx counts 0..frame_len−1 and increments on each accepted sample (s_tvalid && s_tready).
  - pass counts 0..2^log2_avg−1 and increments when idx wraps.
- Read-modify-write pipeline:
  - On accept, assert ren with r_addr=idx.
  - One cycle later, BRAM dout is valid (stage p1) and is written back with w_addr = the registered idx.
  - In pass 0, the written value is the sign-extended sample and dout is ignored.
  - In later passes, the written value is dout + sign-extended sample, computed per rail at ACC_W bits with no overflow possible.
  - Because frame_len >= 2, a read never targets the address being written in the same cycle; no forwarding logic is needed.
- ACCUM state: s_tready=1 on every cycle.
- LAST pass:
  - No write-back occurs.
  - The p1 sum is arithmetically shifted right by log2_avg (truncate toward −inf) and the low 16 bits of each rail are registered into m_tdata.
  - m_tlast is set when idx was frame_len−1.
  - Backpressure: stall = m_tvalid && !m_tready.
  - p1 advances only when !stall.
  - s_tready = (state==LAST) && !(p1_valid && stall).
  - ren fires only on accept, so dout holds its value during a stall.
- Latency: input accept -> m_tvalid is 2 cycles when no stall is present.
- frame_err is set when s_tlast arrives on an accept with idx != frame_len−1, or when s_tlast is missing at idx = frame_len−1. Framing continues to follow idx in either case.
- start pulses during busy are ignored. A start that arrives in the same cycle as done is also ignored.

Decomposition:
- Package sounder_rx_pkg holds:
  - the state enum: IDLE, ACCUM, LAST, FLUSH;
  - the ACC_W derivation;
  - the sc16 I/Q field positions.
- Sub-module: bram_mem, instantiated with DWIDTH = 2*ACC_W and AWIDTH = AWIDTH. All remaining logic stays in one module.

Test Plan:
- frame_len=4, log2_avg=2; four frames with I=Q=100, 200, 300, 400 at every index; m_tready=1 -> four outputs of I=Q=250, m_tlast on the 4th, done 2 cycles later.
- log2_avg=0, frame_len=3, samples (1,−1), (2,−2), (−3,3) -> identical samples out, 2-cycle latency, m_tlast on the 3rd.
- Same as the first case, but m_tready toggles 1,0,0,1,... -> no sample lost or duplicated, s_tready low only while p1 is held, same four averaged values out.
- log2_avg=1, all inputs I=Q=−32768 and then 32767 -> outputs −1 (floor of −0.5), no overflow; all inputs −32768 -> output −32768.
- frame_len=4 with s_tlast on idx 2 -> frame_err=1 and sticky; the run still completes; the next start clears frame_err.
- rst_n low mid-ACCUM -> all outputs are at their reset values immediately; a following start with frame_len=2, log2_avg=1 produces correct averages unaffected by stale RAM contents.

Source files
------------

// File: rtl/sounder_rx_pkg.sv
// Shared types for the sounder RX coherent frame averager.
package sounder_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LAST  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int unsigned SC16_W = 16;
  localparam int unsigned I_LSB  = 16;
  localparam int unsigned Q_LSB  = 0;

  typedef struct packed {
    logic signed [SC16_W-1:0] i;
    logic signed [SC16_W-1:0] q;
  } sc16_t;

  // Per-rail accumulator width: one extra bit per doubling of the frame count.
  function automatic int unsigned acc_w(input int unsigned max_log2_avg);
    return SC16_W + max_log2_avg;
  endfunction

endpackage

// File: rtl/bram_mem.sv
// Simple dual-port block RAM: one synchronous write port, one registered read port.
module bram_mem #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [AWIDTH-1:0] w_addr,
  input  logic [DWIDTH-1:0] din,
  input  logic              ren,
  input  logic [AWIDTH-1:0] r_addr,
  output logic [DWIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wen) mem_q[w_addr] <= din;
  end

  // Read data holds between reads so a stalled consumer keeps seeing it.
  always_ff @(posedge clk) begin
    if (ren) dout_q <= mem_q[r_addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/sounder_rx_avg.sv
// Coherent frame averager: accumulates 2^log2_avg frames in BRAM by read-modify-write,
// then streams out the scaled average on the final pass.
module sounder_rx_avg
  import sounder_rx_pkg::*;
#(
  parameter int unsigned AWIDTH       = 10,
  parameter int unsigned MAX_LOG2_AVG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH:0]   frame_len,
  input  logic [3:0]        log2_avg,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [31:0]       m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  localparam int unsigned ACC_W = acc_w(MAX_LOG2_AVG);
  localparam int unsigned DW    = 2 * ACC_W;
  localparam int unsigned LW    = AWIDTH + 1;
  localparam int unsigned PW    = MAX_LOG2_AVG + 1;
  localparam logic [LW-1:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [3:0]        l2_q, l2_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d;

  logic              p1_valid_q, p1_valid_d;
  logic              p1_out_q, p1_out_d;
  logic              p1_first_q, p1_first_d;
  logic              p1_tlast_q, p1_tlast_d;
  logic [AWIDTH-1:0] p1_idx_q, p1_idx_d;
  sc16_t             p1_smp_q, p1_smp_d;

  logic [31:0]       m_tdata_q, m_tdata_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;

  logic              s_tready_c;
  logic              accept;
  logic              stall;
  logic              p1_en;
  logic              idx_last;
  logic [PW-1:0]     pass_pen;
  logic [LW-1:0]     len_in;
  logic [3:0]        l2_in;

  logic              ren;
  logic              wen;
  logic [DW-1:0]     dout;
  logic [DW-1:0]     w_din;

  logic signed [ACC_W-1:0]  ext_i, ext_q, acc_i, acc_q, sum_i, sum_q;
  logic signed [SC16_W-1:0] avg_i, avg_q;

  bram_mem #(
    .DWIDTH (DW),
    .AWIDTH (AWIDTH)
  ) u_acc_mem (
    .clk    (clk),
    .wen    (wen),
    .w_addr (p1_idx_q),
    .din    (w_din),
    .ren    (ren),
    .r_addr (idx_q),
    .dout   (dout)
  );

  // Stage p1 datapath: sign-extend, accumulate, and scale for the output pass.
  always_comb begin
    ext_i = {{(ACC_W-SC16_W){p1_smp_q.i[SC16_W-1]}}, p1_smp_q.i};
    ext_q = {{(ACC_W-SC16_W){p1_smp_q.q[SC16_W-1]}}, p1_smp_q.q};
    acc_i = dout[ACC_W +: ACC_W];
    acc_q = dout[0 +: ACC_W];
    sum_i = p1_first_q ? ext_i : acc_i + ext_i;
    sum_q = p1_first_q ? ext_q : acc_q + ext_q;
    avg_i = SC16_W'(sum_i >>> l2_q);
    avg_q = SC16_W'(sum_q >>> l2_q);
    w_din = {sum_i, sum_q};
  end

  // Start-time configuration clamping.
  always_comb begin
    len_in = frame_len;
    if (frame_len < LW'(2))        len_in = LW'(2);
    else if (frame_len > LEN_MAX)  len_in = LEN_MAX;
    l2_in = log2_avg;
    if (32'(log2_avg) > MAX_LOG2_AVG) l2_in = 4'(MAX_LOG2_AVG);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    l2_d        = l2_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    p1_valid_d  = p1_valid_q;
    p1_out_d    = p1_out_q;
    p1_first_d  = p1_first_q;
    p1_tlast_d  = p1_tlast_q;
    p1_idx_d    = p1_idx_q;
    p1_smp_d    = p1_smp_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;

    stall      = m_tvalid_q && !m_tready;
    p1_en      = !(p1_valid_q && stall);
    s_tready_c = (state_q == ACCUM) || ((state_q == LAST) && p1_en);
    accept     = s_tvalid && s_tready_c;
    idx_last   = (idx_q == AWIDTH'(len_q - LW'(1)));
    pass_pen   = (PW'(1) << l2_q) - PW'(2);
    ren        = accept;
    wen        = p1_valid_q && !p1_out_q;

    // Output register: drain on handshake, refill from p1 when not stalled.
    if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end
    if (p1_valid_q && p1_out_q && !stall) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = {avg_i, avg_q};
      m_tlast_d  = p1_tlast_q;
    end

    if (p1_en) begin
      p1_valid_d = accept;
      p1_out_d   = (state_q == LAST);
      p1_first_d = (pass_q == '0);
      p1_tlast_d = idx_last;
      p1_idx_d   = idx_q;
      p1_smp_d   = '{i: s_tdata[I_LSB +: SC16_W], q: s_tdata[Q_LSB +: SC16_W]};
    end

    if (accept) begin
      if (s_tlast != idx_last) frame_err_d = 1'b1;
      if (idx_last) begin
        idx_d  = '0;
        pass_d = pass_q + PW'(1);
      end else begin
        idx_d  = idx_q + AWIDTH'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        // A start coinciding with done belongs to the run just finished.
        if (start && !done_q) begin
          len_d       = len_in;
          l2_d        = l2_in;
          idx_d       = '0;
          pass_d      = '0;
          frame_err_d = 1'b0;
          state_d     = (l2_in == 4'd0) ? LAST : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && idx_last && (pass_q == pass_pen)) state_d = LAST;
      end
      LAST: begin
        if (accept && idx_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!p1_valid_q && m_tvalid_q && m_tready && m_tlast_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      l2_q        <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_out_q    <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_tlast_q  <= 1'b0;
      p1_idx_q    <= '0;
      p1_smp_q    <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      l2_q        <= l2_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      p1_valid_q  <= p1_valid_d;
      p1_out_q    <= p1_out_d;
      p1_first_q  <= p1_first_d;
      p1_tlast_q  <= p1_tlast_d;
      p1_idx_q    <= p1_idx_d;
      p1_smp_q    <= p1_smp_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign s_tready  = s_tready_c;
  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;

endmodule

// File: tb/tb_sounder_rx_avg.sv
// Directed bench for sounder_rx_avg with an output scoreboard and protocol monitor.
module tb_sounder_rx_avg;

  localparam int unsigned AWIDTH       = 10;
  localparam int unsigned MAX_LOG2_AVG = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [AWIDTH:0]   frame_len;
  logic [3:0]        log2_avg;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic [31:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;

  int          checks    = 0;
  int          failures  = 0;
  logic [32:0] exp_q[$];
  bit          rdy_mode  = 1'b0;
  logic        hs_last_prev = 1'b0;
  logic        stall_prev   = 1'b0;
  logic [33:0] word_prev    = '0;

  sounder_rx_avg #(
    .AWIDTH       (AWIDTH),
    .MAX_LOG2_AVG (MAX_LOG2_AVG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .log2_avg  (log2_avg),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Downstream ready: constant high, or the 1,0,0,1 repeating pattern.
  initial begin
    int k;
    k = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        m_tready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pop, done timing and stall-hold checks.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_last_prev = 1'b0;
        stall_prev   = 1'b0;
        continue;
      end
      if (done || hs_last_prev) check("done_timing", 64'(done), 64'(hs_last_prev));
      if (stall_prev) check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'(word_prev));
      if (m_tvalid && m_tready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_sample", 64'({m_tlast, m_tdata}), 64'(e));
        end
      end
      hs_last_prev = m_tvalid && m_tready && m_tlast;
      stall_prev   = m_tvalid && !m_tready;
      word_prev    = {m_tvalid, m_tlast, m_tdata};
    end
  end

  task automatic pulse_start(input logic [AWIDTH:0] len, input logic [3:0] l2);
    frame_len = len;
    log2_avg  = l2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input int vi, input int vq, input logic last);
    int n;
    n = 0;
    s_tdata  = {16'(vi), 16'(vq)};
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) check("s_tready_timeout", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Frame of samples (base + step*k, -(base + step*k)); tlast at tlast_pos.
  task automatic send_frame(input int len, input int base, input int step, input int tlast_pos);
    for (int k = 0; k < len; k++) send(base + step * k, -(base + step * k), k == tlast_pos);
  endtask

  task automatic expect_out(input int vi, input int vq, input logic last);
    exp_q.push_back({last, 16'(vi), 16'(vq)});
  endtask

  task automatic wait_done(input bit poke);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    if (poke) begin
      frame_len = 11'd2;
      log2_avg  = 4'd0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("start_on_done_ignored", 64'(busy), 64'd0);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    log2_avg  = '0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    #2;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_s_tready",  64'(s_tready),  64'd0);
    check("rst_m_tvalid",  64'(m_tvalid),  64'd0);
    check("rst_m_tlast",   64'(m_tlast),   64'd0);
    check("rst_m_tdata",   64'(m_tdata),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-frame average with a stray start mid-run.
    pulse_start(11'd4, 4'd2);
    check("busy_after_start", 64'(busy), 64'd1);
    for (int f = 0; f < 4; f++) begin
      if (f == 3) for (int k = 0; k < 4; k++) expect_out(250 + 10 * k, -(250 + 10 * k), k == 3);
      send_frame(4, 100 * (f + 1), 10, 3);
      if (f == 1) pulse_start(11'd2, 4'd0);
    end
    wait_done(1'b0);
    check("t1_frame_err", 64'(frame_err), 64'd0);
    check("t1_busy_idle", 64'(busy), 64'd0);

    // Pass-through with 2-cycle latency; start coinciding with done is ignored.
    pulse_start(11'd3, 4'd0);
    expect_out(1, -1, 1'b0);
    expect_out(2, -2, 1'b0);
    expect_out(-3, 3, 1'b1);
    send(1, -1, 1'b0);
    @(negedge clk);
    check("lat_cycle1_m_tvalid", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_m_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    send(2, -2, 1'b0);
    send(-3, 3, 1'b1);
    wait_done(1'b1);

    // Four-frame average under output backpressure.
    rdy_mode = 1'b1;
    pulse_start(11'd4, 4'd2);
    for (int f = 0; f < 4; f++) begin
      if (f == 3) for (int k = 0; k < 4; k++) expect_out(250 + 10 * k, -(250 + 10 * k), k == 3);
      send_frame(4, 100 * (f + 1), 10, 3);
    end
    wait_done(1'b0);
    rdy_mode = 1'b0;

    // Full-scale extremes: floor of -0.5 and most-negative average.
    pulse_start(11'd2, 4'd1);
    expect_out(-1, -1, 1'b0);
    expect_out(-1, -1, 1'b1);
    send(-32768, -32768, 1'b0);
    send(-32768, -32768, 1'b1);
    send(32767, 32767, 1'b0);
    send(32767, 32767, 1'b1);
    wait_done(1'b0);
    pulse_start(11'd2, 4'd1);
    expect_out(-32768, -32768, 1'b0);
    expect_out(-32768, -32768, 1'b1);
    for (int k = 0; k < 4; k++) send(-32768, -32768, (k % 2) == 1);
    wait_done(1'b0);

    // frame_len = 0 behaves as a 2-sample frame.
    pulse_start(11'd0, 4'd0);
    expect_out(5, 6, 1'b0);
    expect_out(7, 8, 1'b1);
    send(5, 6, 1'b0);
    send(7, 8, 1'b1);
    wait_done(1'b0);

    // Misplaced tlast raises a sticky frame_err; the run still completes.
    pulse_start(11'd4, 4'd1);
    for (int k = 0; k < 4; k++) expect_out(15, -15, k == 3);
    send_frame(4, 10, 0, 2);
    check("t5_frame_err_set", 64'(frame_err), 64'd1);
    send_frame(4, 20, 0, 3);
    wait_done(1'b0);
    check("t5_frame_err_sticky", 64'(frame_err), 64'd1);

    // Next start clears frame_err; reset mid-accumulation aborts the run.
    pulse_start(11'd4, 4'd2);
    check("t6_frame_err_cleared", 64'(frame_err), 64'd0);
    send_frame(4, 50, 1, 3);
    send(60, -60, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",     64'(busy),     64'd0);
    check("t6_rst_s_tready", 64'(s_tready), 64'd0);
    check("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_rst_done",     64'(done),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(11'd2, 4'd1);
    expect_out(8, -8, 1'b0);
    expect_out(10, -10, 1'b1);
    send(7, -7, 1'b0);
    send(8, -8, 1'b1);
    send(9, -9, 1'b0);
    send(12, -12, 1'b1);
    wait_done(1'b0);

    check("sb_empty_final", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
